// File: rtl/uart_rx_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo_ctrl
//   Receive-side buffer between the UART receiver and the APB register block.
//   Each byte strobed by the receiver is stored with its parity/framing error
//   bits in a DEPTH-entry first-word-fall-through FIFO. The block keeps sticky
//   overflow status and raises a threshold interrupt and a character-timeout
//   interrupt (timed in x16 baud enable ticks).
//
//   Handshake: there is no backpressure. rx_wr and rd_en are single-cycle
//   strobes sampled on the rising clk edge. A write is taken whenever a slot
//   is free after the same-edge pop. A pop happens only if the FIFO holds
//   data. rd_data/rd_perr/rd_ferr always show the head entry and read as 0
//   when the FIFO is empty.
//
// Ports
//   clk, reset_n            clock, synchronous active-low reset
//   baud_en                 x16 baud enable pulse
//   rx_wr, rx_data,
//   rx_perr, rx_ferr        receiver write strobe and entry fields
//   rd_en                   pop strobe from the bus interface
//   thresh                  threshold interrupt level (0 = disabled)
//   clr_err                 clears overflow
//   rd_data, rd_perr,
//   rd_ferr                 head entry (fall-through)
//   rx_rdy, full, count     occupancy status
//   overflow                sticky "a byte was dropped"
//   thresh_irq, timeout_irq registered level interrupts
//   dbg_state               timeout FSM state (0 IDLE, 1 ARMED, 2 EXPIRED)
// ---------------------------------------------------------------------------
module uart_rx_fifo_ctrl #(
  parameter int DEPTH         = 16,
  parameter int TIMEOUT_TICKS = 640,
  localparam int AW           = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          baud_en,
  input  logic          rx_wr,
  input  logic [7:0]    rx_data,
  input  logic          rx_perr,
  input  logic          rx_ferr,
  input  logic          rd_en,
  input  logic [AW-1:0] thresh,
  input  logic          clr_err,
  output logic [7:0]    rd_data,
  output logic          rd_perr,
  output logic          rd_ferr,
  output logic          rx_rdy,
  output logic          full,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          thresh_irq,
  output logic          timeout_irq,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    EXPIRED = 2'd2
  } tmo_state_t;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [9:0]  TLAST    = 10'(TIMEOUT_TICKS - 1);

  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count_nxt;
  logic [9:0]    tcnt;
  logic [9:0]    tcnt_nxt;
  tmo_state_t    state;
  tmo_state_t    state_nxt;

  logic       wr_acc;
  logic       rd_acc;
  logic       drop;
  logic       activity;
  logic [9:0] head;

  // A pop frees a slot on the same edge, so a write into a full FIFO is
  // still accepted when rd_en is present.
  assign rd_acc   = rd_en && (count != '0);
  assign wr_acc   = rx_wr && ((count != FULL_CNT) || rd_en);
  assign drop     = rx_wr && (count == FULL_CNT) && !rd_en;
  assign activity = rx_wr || rd_en;

  always_comb begin
    count_nxt = count;
    if (wr_acc && !rd_acc) begin
      count_nxt = count + 1'b1;
    end else if (rd_acc && !wr_acc) begin
      count_nxt = count - 1'b1;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (reset_n && wr_acc) begin
      mem[wptr] <= {rx_ferr, rx_perr, rx_data};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      thresh_irq <= 1'b0;
    end else begin
      if (wr_acc) wptr <= wptr + 1'b1;
      if (rd_acc) rptr <= rptr + 1'b1;
      count <= count_nxt;
      // A new drop wins over a coincident clear.
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      thresh_irq <= (thresh != '0) && (count_nxt >= {1'b0, thresh});
    end
  end

  // Timeout FSM: state register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      tcnt        <= '0;
      timeout_irq <= 1'b0;
    end else begin
      state       <= state_nxt;
      tcnt        <= tcnt_nxt;
      timeout_irq <= (state_nxt == EXPIRED);
    end
  end

  // Timeout FSM: next state. An empty FIFO forces IDLE from any state;
  // write/read activity takes priority over a baud tick.
  always_comb begin
    state_nxt = state;
    tcnt_nxt  = tcnt;
    if (count_nxt == '0) begin
      state_nxt = IDLE;
      tcnt_nxt  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (wr_acc) begin
            state_nxt = ARMED;
            tcnt_nxt  = '0;
          end
        end
        ARMED: begin
          if (activity) begin
            tcnt_nxt = '0;
          end else if (baud_en) begin
            if (tcnt == TLAST) begin
              state_nxt = EXPIRED;
              tcnt_nxt  = '0;
            end else begin
              tcnt_nxt = tcnt + 1'b1;
            end
          end
        end
        EXPIRED: begin
          if (activity) begin
            state_nxt = ARMED;
            tcnt_nxt  = '0;
          end
        end
        default: begin
          state_nxt = IDLE;
          tcnt_nxt  = '0;
        end
      endcase
    end
  end

  assign head      = mem[rptr];
  assign rx_rdy    = (count != '0);
  assign full      = (count == FULL_CNT);
  assign rd_data   = rx_rdy ? head[7:0] : 8'h00;
  assign rd_perr   = rx_rdy ? head[8]   : 1'b0;
  assign rd_ferr   = rx_rdy ? head[9]   : 1'b0;
  assign dbg_state = state;

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo_ctrl
//   Directed and random stimulus against a queue-based reference model.
//   DUT built with DEPTH=16 and TIMEOUT_TICKS=8.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo_ctrl;

  localparam int DEPTH = 16;
  localparam int TICKS = 8;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n = 1'b0;
  logic       baud_en = 1'b0;
  logic       rx_wr = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_perr = 1'b0;
  logic       rx_ferr = 1'b0;
  logic       rd_en = 1'b0;
  logic [3:0] thresh = '0;
  logic       clr_err = 1'b0;
  logic [7:0] rd_data;
  logic       rd_perr;
  logic       rd_ferr;
  logic       rx_rdy;
  logic       full;
  logic [4:0] count;
  logic       overflow;
  logic       thresh_irq;
  logic       timeout_irq;
  logic [1:0] dbg_state;

  uart_rx_fifo_ctrl #(.DEPTH(DEPTH), .TIMEOUT_TICKS(TICKS)) dut (
    .clk(clk), .reset_n(reset_n), .baud_en(baud_en),
    .rx_wr(rx_wr), .rx_data(rx_data), .rx_perr(rx_perr), .rx_ferr(rx_ferr),
    .rd_en(rd_en), .thresh(thresh), .clr_err(clr_err),
    .rd_data(rd_data), .rd_perr(rd_perr), .rd_ferr(rd_ferr),
    .rx_rdy(rx_rdy), .full(full), .count(count), .overflow(overflow),
    .thresh_irq(thresh_irq), .timeout_irq(timeout_irq), .dbg_state(dbg_state)
  );

  // reference model: entries as {ferr, perr, data}
  logic [9:0] exp_q[$];
  bit m_ovf;
  bit m_tirq_th;
  bit m_tmo;
  int idle_ticks;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [9:0] h;
    int sz;
    sz = exp_q.size();
    h  = (sz != 0) ? exp_q[0] : 10'h000;
    check({tag, ".count"},  32'(count), 32'(sz));
    check({tag, ".rx_rdy"}, 32'(rx_rdy), 32'(sz != 0));
    check({tag, ".full"},   32'(full), 32'(sz == DEPTH));
    check({tag, ".rd_data"}, 32'(rd_data), 32'(h[7:0]));
    check({tag, ".rd_perr"}, 32'(rd_perr), 32'(h[8]));
    check({tag, ".rd_ferr"}, 32'(rd_ferr), 32'(h[9]));
    check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    check({tag, ".thresh_irq"}, 32'(thresh_irq), 32'(m_tirq_th));
    check({tag, ".timeout_irq"}, 32'(timeout_irq), 32'(m_tmo));
    check({tag, ".state"}, 32'(dbg_state), (sz == 0) ? 32'd0 : (m_tmo ? 32'd2 : 32'd1));
  endtask

  // driver: one clock with the given strobes, then model update and check
  task automatic cycle(input string tag, input bit wr, input logic [9:0] ent,
                       input bit rd, input bit baud, input bit clr);
    int sz;
    bit rd_ok, wr_ok, drop;
    rx_wr = wr;
    {rx_ferr, rx_perr, rx_data} = ent;
    rd_en = rd;
    baud_en = baud;
    clr_err = clr;
    sz    = exp_q.size();
    rd_ok = rd && (sz > 0);
    wr_ok = wr && ((sz < DEPTH) || rd);
    drop  = wr && (sz == DEPTH) && !rd;
    @(posedge clk);
    #1;
    if (rd_ok) void'(exp_q.pop_front());
    if (wr_ok) exp_q.push_back(ent);
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    m_tirq_th = (thresh != 0) && (exp_q.size() >= int'(thresh));
    if (exp_q.size() == 0) begin
      idle_ticks = 0;
      m_tmo = 1'b0;
    end else if (wr || rd) begin
      idle_ticks = 0;
      m_tmo = 1'b0;
    end else if (baud && !m_tmo) begin
      idle_ticks++;
      if (idle_ticks == TICKS) m_tmo = 1'b1;
    end
    rx_wr = 1'b0; rd_en = 1'b0; baud_en = 1'b0; clr_err = 1'b0;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    rx_wr = 1'b0; rd_en = 1'b0; baud_en = 1'b0; clr_err = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    exp_q.delete();
    m_ovf = 1'b0; m_tirq_th = 1'b0; m_tmo = 1'b0; idle_ticks = 0;
    check_all(tag);
  endtask

  function automatic logic [9:0] rnd_ent(input logic [7:0] d);
    logic [1:0] e;
    e = 2'($urandom_range(0, 3));
    return {e, d};
  endfunction

  initial begin
    // reset state
    do_reset("reset");
    do_reset("reset2");

    // reset discards stored data
    for (int i = 0; i < 3; i++) cycle("rst_fill", 1, {2'b00, 8'(8'h10 + i)}, 0, 0, 0);
    do_reset("rst_mid");

    // ordering across pointer wrap, error bits follow bytes
    for (int i = 0; i < 20; i++) begin
      bit rd;
      rd = (i >= 4) && ($urandom_range(0, 3) != 0);
      if (exp_q.size() == DEPTH) rd = 1;
      cycle("order_wr", 1, rnd_ent(8'(i)), rd, 0, 0);
      if ($urandom_range(0, 2) == 0) cycle("order_rd", 0, '0, 1, 0, 0);
    end
    while (exp_q.size() != 0) cycle("order_drain", 0, '0, 1, 0, 0);

    // full, overflow, write+read while full, clear
    for (int i = 0; i < DEPTH; i++) cycle("full_wr", 1, rnd_ent(8'(8'h30 + i)), 0, 0, 0);
    cycle("ovf_drop", 1, {2'b11, 8'hAA}, 0, 0, 0);
    cycle("full_wr_rd", 1, {2'b01, 8'hAB}, 1, 0, 0);
    cycle("ovf_clr_drop", 1, {2'b00, 8'hAC}, 0, 0, 1);
    cycle("ovf_clr", 0, '0, 0, 0, 1);
    while (exp_q.size() != 0) cycle("full_drain", 0, '0, 1, 0, 0);

    // empty edge cases
    cycle("empty_rd", 0, '0, 1, 0, 0);
    cycle("empty_wr_rd", 1, {2'b10, 8'h55}, 1, 0, 0);
    cycle("empty_pop", 0, '0, 1, 0, 0);

    // threshold
    thresh = 4'd4;
    for (int i = 0; i < 4; i++) cycle("thr_wr", 1, rnd_ent(8'(8'h60 + i)), 0, 0, 0);
    cycle("thr_rd", 0, '0, 1, 0, 0);
    cycle("thr_wr2", 1, rnd_ent(8'h64), 0, 0, 0);
    while (exp_q.size() != 0) cycle("thr_drain", 0, '0, 1, 0, 0);
    thresh = 4'd0;
    for (int i = 0; i < 6; i++) cycle("thr0_wr", 1, rnd_ent(8'(8'h70 + i)), 0, 0, 0);
    while (exp_q.size() != 0) cycle("thr0_drain", 0, '0, 1, 0, 0);

    // timeout after TICKS idle baud ticks, cleared by draining read
    cycle("tmo_wr", 1, rnd_ent(8'h80), 0, 0, 0);
    for (int i = 0; i < TICKS; i++) begin
      cycle("tmo_tick", 0, '0, 0, 1, 0);
      cycle("tmo_gap", 0, '0, 0, 0, 0);
    end
    cycle("tmo_extra", 0, '0, 0, 1, 0);
    cycle("tmo_rd", 0, '0, 1, 0, 0);

    // write at tick 5 restarts the count
    cycle("tmo2_wr", 1, rnd_ent(8'h81), 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle("tmo2_tick", 0, '0, 0, 1, 0);
    cycle("tmo2_wr_tick", 1, rnd_ent(8'h82), 0, 1, 0);
    for (int i = 0; i < TICKS; i++) cycle("tmo2_tick2", 0, '0, 0, 1, 0);
    cycle("tmo2_rd_exp", 0, '0, 1, 0, 0);
    for (int i = 0; i < TICKS; i++) cycle("tmo2_tick3", 0, '0, 0, 1, 0);
    cycle("tmo2_drain", 0, '0, 1, 0, 0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) thresh = 4'($urandom_range(0, 15));
      cycle("rand", $urandom_range(0, 9) < 6, rnd_ent(8'($urandom)),
            $urandom_range(0, 9) < 4, $urandom_range(0, 2) == 0,
            $urandom_range(0, 19) == 0);
    end
    do_reset("reset_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
